attack_controller: RTL

Per-frame projectile controller for the player's attack. It runs once per game frame, turns the fire key into a single projectile, and moves it in the player's facing direction. The projectile ends on range expiry, screen edge or enemy hit, and a cooldown follows. Its registered position and active flag feed the attack sprite ROM address stage, which produces `is_attack`/`attack_index` for the colour mapper.

---
 rtl/boxhead_pkg.sv | 21 ++
 rtl/attack_hit_detect.sv | 38 +++
 rtl/attack_controller.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/boxhead_pkg.sv
// Shared types and screen constants for the boxhead game slice.
package boxhead_pkg;

    localparam int ENEMY_NUM     = 4;
    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLYING   = 2'd1,
        COOLDOWN = 2'd2
    } attack_state_t;

endpackage

// File: rtl/attack_hit_detect.sv
// Combinational projectile/enemy AABB overlap with lowest-index priority.
module attack_hit_detect
    import boxhead_pkg::*;
#(
    parameter int ATTACK_SIZE = 8,
    parameter int ENEMY_SIZE  = 32
) (
    input  logic [9:0]           attack_x,
    input  logic [9:0]           attack_y,
    input  logic [9:0]           enemy_x     [ENEMY_NUM],
    input  logic [9:0]           enemy_y     [ENEMY_NUM],
    input  logic                 enemy_alive [ENEMY_NUM],
    output logic                 hit_valid,
    output logic [ENEMY_NUM-1:0] hit_onehot
);

    localparam logic [10:0] A_SZ = 11'(ATTACK_SIZE);
    localparam logic [10:0] E_SZ = 11'(ENEMY_SIZE);

    logic [ENEMY_NUM-1:0] overlap;

    // Sums are widened to 11 bits so edge-of-range coordinates never wrap.
    always_comb begin
        overlap = '0;
        for (int i = 0; i < ENEMY_NUM; i++) begin
            overlap[i] = enemy_alive[i]
                && ({1'b0, attack_x}   < {1'b0, enemy_x[i]} + E_SZ)
                && ({1'b0, enemy_x[i]} < {1'b0, attack_x}   + A_SZ)
                && ({1'b0, attack_y}   < {1'b0, enemy_y[i]} + E_SZ)
                && ({1'b0, enemy_y[i]} < {1'b0, attack_y}   + A_SZ);
        end
    end

    // x & -x isolates the lowest set bit.
    assign hit_onehot = overlap & (~overlap + ENEMY_NUM'(1));
    assign hit_valid  = |overlap;

endmodule

// File: rtl/attack_controller.sv
// Per-frame player projectile FSM (IDLE/FLYING/COOLDOWN).
// Enemy hit detection is compiled in only when ATTACK_HIT_DETECT_EN is defined.
module attack_controller
    import boxhead_pkg::*;
#(
    parameter int SCREEN_W        = SCREEN_WIDTH,
    parameter int SCREEN_H        = SCREEN_HEIGHT,
    parameter int PLAYER_SIZE     = 32,
    parameter int ATTACK_SIZE     = 8,
    parameter int ENEMY_SIZE      = 32,
    parameter int ATTACK_SPEED    = 4,
    parameter int ATTACK_RANGE    = 60,
    parameter int COOLDOWN_FRAMES = 15
) (
    input  logic       game_frame_clk_rising_edge,
    input  logic       Reset,
    input  logic       game_active,
    input  logic       fire,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    input  logic [1:0] player_dir,
    input  logic [9:0] enemy_x     [ENEMY_NUM],
    input  logic [9:0] enemy_y     [ENEMY_NUM],
    input  logic       enemy_alive [ENEMY_NUM],
    output logic       attack_active,
    output logic [9:0] attack_x,
    output logic [9:0] attack_y,
    output logic [1:0] attack_dir,
    output logic       cooldown_busy,
    output logic       enemy_hit   [ENEMY_NUM]
);

    localparam int FC_W = $clog2(ATTACK_RANGE) + 1;
    localparam int CD_W = $clog2(COOLDOWN_FRAMES) + 1;

    localparam logic [FC_W-1:0] RANGE_LAST = FC_W'(ATTACK_RANGE - 1);
    localparam logic [CD_W-1:0] CD_LAST    = CD_W'(COOLDOWN_FRAMES - 1);
    localparam logic [10:0]     SPEED_11   = 11'(ATTACK_SPEED);
    localparam logic [9:0]      SPEED_10   = 10'(ATTACK_SPEED);
    localparam logic [10:0]     MAX_X_11   = 11'(SCREEN_W - ATTACK_SIZE);
    localparam logic [10:0]     MAX_Y_11   = 11'(SCREEN_H - ATTACK_SIZE);
    localparam logic [9:0]      SPAWN_OFS  = 10'((PLAYER_SIZE - ATTACK_SIZE) / 2);

    attack_state_t        state, state_n;
    dir_t                 dir_q, dir_n;
    logic [9:0]           ax_n, ay_n;
    logic [FC_W-1:0]      flight_cnt, flight_cnt_n;
    logic [CD_W-1:0]      cd_cnt, cd_cnt_n;
    logic [ENEMY_NUM-1:0] hit_q, hit_n;
    logic [ENEMY_NUM-1:0] hit_onehot;
    logic                 hit_valid;
    logic                 fire_prev;
    logic                 fire_edge;
    logic                 edge_out;

`ifdef ATTACK_HIT_DETECT_EN
    attack_hit_detect #(
        .ATTACK_SIZE (ATTACK_SIZE),
        .ENEMY_SIZE  (ENEMY_SIZE)
    ) u_hit_detect (
        .attack_x    (attack_x),
        .attack_y    (attack_y),
        .enemy_x     (enemy_x),
        .enemy_y     (enemy_y),
        .enemy_alive (enemy_alive),
        .hit_valid   (hit_valid),
        .hit_onehot  (hit_onehot)
    );
`else
    logic unused_enemy;

    always_comb begin
        unused_enemy = 1'b0;
        for (int i = 0; i < ENEMY_NUM; i++) begin
            unused_enemy = unused_enemy ^ enemy_alive[i] ^ (^enemy_x[i]) ^ (^enemy_y[i]);
        end
    end

    assign hit_valid  = 1'b0;
    assign hit_onehot = '0;
`endif

    assign fire_edge  = fire & ~fire_prev;
    assign attack_dir = dir_q;

    // Would the next step leave [0, SCREEN-ATTACK_SIZE]?
    always_comb begin
        case (dir_q)
            UP:      edge_out = {1'b0, attack_y} < SPEED_11;
            DOWN:    edge_out = ({1'b0, attack_y} + SPEED_11) > MAX_Y_11;
            LEFT:    edge_out = {1'b0, attack_x} < SPEED_11;
            default: edge_out = ({1'b0, attack_x} + SPEED_11) > MAX_X_11;
        endcase
    end

    always_comb begin
        state_n      = state;
        ax_n         = attack_x;
        ay_n         = attack_y;
        dir_n        = dir_q;
        flight_cnt_n = flight_cnt;
        cd_cnt_n     = cd_cnt;
        hit_n        = '0;

        if (!game_active) begin
            state_n      = IDLE;
            ax_n         = '0;
            ay_n         = '0;
            dir_n        = UP;
            flight_cnt_n = '0;
            cd_cnt_n     = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire_edge) begin
                        state_n      = FLYING;
                        ax_n         = player_x + SPAWN_OFS;
                        ay_n         = player_y + SPAWN_OFS;
                        dir_n        = dir_t'(player_dir);
                        flight_cnt_n = '0;
                    end
                end
                FLYING: begin
                    // Hit outranks range and edge so its pulse is never lost.
                    if (hit_valid) begin
                        state_n  = COOLDOWN;
                        cd_cnt_n = '0;
                        hit_n    = hit_onehot;
                    end else if (flight_cnt == RANGE_LAST || edge_out) begin
                        state_n  = COOLDOWN;
                        cd_cnt_n = '0;
                    end else begin
                        flight_cnt_n = flight_cnt + FC_W'(1);
                        case (dir_q)
                            UP:      ay_n = attack_y - SPEED_10;
                            DOWN:    ay_n = attack_y + SPEED_10;
                            LEFT:    ax_n = attack_x - SPEED_10;
                            default: ax_n = attack_x + SPEED_10;
                        endcase
                    end
                end
                COOLDOWN: begin
                    if (cd_cnt == CD_LAST) begin
                        state_n = IDLE;
                    end else begin
                        cd_cnt_n = cd_cnt + CD_W'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge game_frame_clk_rising_edge) begin
        if (Reset) begin
            state         <= IDLE;
            attack_x      <= '0;
            attack_y      <= '0;
            dir_q         <= UP;
            flight_cnt    <= '0;
            cd_cnt        <= '0;
            hit_q         <= '0;
            attack_active <= 1'b0;
            cooldown_busy <= 1'b0;
            fire_prev     <= 1'b0;
        end else begin
            state         <= state_n;
            attack_x      <= ax_n;
            attack_y      <= ay_n;
            dir_q         <= dir_n;
            flight_cnt    <= flight_cnt_n;
            cd_cnt        <= cd_cnt_n;
            hit_q         <= hit_n;
            attack_active <= (state_n == FLYING);
            cooldown_busy <= (state_n == COOLDOWN);
            fire_prev     <= fire;
        end
    end

    always_comb begin
        for (int i = 0; i < ENEMY_NUM; i++) begin
            enemy_hit[i] = hit_q[i];
        end
    end

endmodule
